// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the fetch queue and its storage.
package cpu_pkg;

    localparam logic [15:0] NOP_ENC       = 16'h0800;
    localparam int unsigned PAIR_W        = 32;
    localparam int unsigned DEFAULT_DEPTH = 4;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] ir;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle; the queue uses the slave side, its neighbours the master side.
interface fetch_queue_if #(
    parameter int unsigned PTR_W = 2
);
    logic             in_valid;
    logic [15:0]      in_pc;
    logic [15:0]      in_ir;
    logic             in_ready;
    logic             out_valid;
    logic [15:0]      out_pc;
    logic [15:0]      out_ir;
    logic [15:0]      out_pc_next;
    logic             out_ready;
    logic             flush;
    logic [PTR_W:0]   count;

    modport master (
        output in_valid, in_pc, in_ir, out_ready, flush,
        input  in_ready, out_valid, out_pc, out_ir, out_pc_next, count
    );

    modport slave (
        input  in_valid, in_pc, in_ir, out_ready, flush,
        output in_ready, out_valid, out_pc, out_ir, out_pc_next, count
    );
endinterface

// File: rtl/fq_storage.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port, no reset.
module fq_storage #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue between fetch and decode; flushable, shows NOP to decode when empty.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned PTR_W  = $clog2(DEPTH),
    parameter logic [15:0] NOP_IR = NOP_ENC
) (
    input logic          clk,
    input logic          rst,
    fetch_queue_if.slave q
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [PTR_W-1:0] wp_q, wp_d;
    logic [PTR_W-1:0] rp_q, rp_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             push, pop;
    fq_entry_t        wr_entry, rd_entry;

    // Ready/valid come from registered state only, so a full queue cannot accept while popping.
    assign q.in_ready  = (cnt_q != FULL_CNT);
    assign q.out_valid = (cnt_q != '0);
    assign push        = q.in_valid & q.in_ready;
    assign pop         = q.out_valid & q.out_ready;

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (q.flush) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) wp_d = wp_q + PTR_ONE;
            if (pop)  rp_d = rp_q + PTR_ONE;
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNT_ONE;
                2'b01:   cnt_d = cnt_q - CNT_ONE;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    assign wr_entry = '{pc: q.in_pc, ir: q.in_ir};

    // A push coinciding with flush is dropped, so the write is suppressed as well.
    fq_storage #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .WIDTH (PAIR_W)
    ) u_storage (
        .clk   (clk),
        .we    (push & ~q.flush),
        .waddr (wp_q),
        .wdata (wr_entry),
        .raddr (rp_q),
        .rdata (rd_entry)
    );

    assign q.out_pc      = q.out_valid ? rd_entry.pc : 16'h0000;
    assign q.out_ir      = q.out_valid ? rd_entry.ir : NOP_IR;
    assign q.out_pc_next = q.out_pc + 16'd1;
    assign q.count       = cnt_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a scoreboard queue models the FIFO and is compared each cycle.
module tb_fetch_queue;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fetch_queue_if #(.PTR_W(2)) fq ();

    fetch_queue #(
        .DEPTH  (4),
        .PTR_W  (2),
        .NOP_IR (16'h0800)
    ) dut (
        .clk (clk),
        .rst (rst),
        .q   (fq)
    );

    int          n_vec = 0;
    int          n_err = 0;
    bit          known = 1'b0;
    logic [31:0] sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive at the falling edge, compare settled outputs, advance the model.
    task automatic step(input logic r, input logic v, input logic [15:0] pc,
                        input logic [15:0] ir, input logic rdy, input logic fl);
        int          exp_cnt;
        logic [15:0] exp_pc;
        logic [15:0] exp_ir;
        logic [15:0] exp_nxt;
        logic [31:0] hd;
        bit          do_push;
        bit          do_pop;
        @(negedge clk);
        rst          = r;
        fq.in_valid  = v;
        fq.in_pc     = pc;
        fq.in_ir     = ir;
        fq.out_ready = rdy;
        fq.flush     = fl;
        #1;
        if (known) begin
            exp_cnt = sb.size();
            if (exp_cnt != 0) begin
                hd     = sb[0];
                exp_pc = hd[31:16];
                exp_ir = hd[15:0];
            end else begin
                exp_pc = 16'h0000;
                exp_ir = 16'h0800;
            end
            exp_nxt = exp_pc + 16'd1;
            check("count",       32'(fq.count),  32'(exp_cnt));
            check("in_ready",    32'(fq.in_ready),  32'(exp_cnt != 4));
            check("out_valid",   32'(fq.out_valid), 32'(exp_cnt != 0));
            check("out_pc",      32'(fq.out_pc),      32'(exp_pc));
            check("out_ir",      32'(fq.out_ir),      32'(exp_ir));
            check("out_pc_next", 32'(fq.out_pc_next), 32'(exp_nxt));
        end
        if (r || fl) begin
            sb.delete();
            if (r) known = 1'b1;
        end else begin
            do_pop  = rdy && (sb.size() > 0);
            do_push = v && (sb.size() < 4);
            if (do_pop)  void'(sb.pop_front());
            if (do_push) sb.push_back({pc, ir});
        end
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, 16'h0, 16'h0, rdy, 1'b0);
    endtask

    initial begin
        logic [15:0] pc;
        fq.in_valid  = 1'b0;
        fq.in_pc     = '0;
        fq.in_ir     = '0;
        fq.out_ready = 1'b0;
        fq.flush     = 1'b0;

        // Reset held two cycles with fetch offering
        step(1'b1, 1'b1, 16'h1234, 16'h5678, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h1234, 16'h5678, 1'b0, 1'b0);
        idle(1'b0);

        // Fill to full, then a fifth offer that must be ignored
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 16'h0010 + 16'(i), 16'hA000 + 16'(i), 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h0014, 16'hA004, 1'b0, 1'b0);
        idle(1'b0);

        // Drain in order, then empty
        for (int i = 0; i < 4; i++) idle(1'b1);
        idle(1'b0);

        // Streaming across the pointer wrap and the 16-bit PC wrap
        pc = 16'hFFFE;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, pc, 16'hB000 + 16'(i), 1'b1, 1'b0);
            pc = pc + 16'd1;
        end
        idle(1'b1);
        idle(1'b0);

        // Flush beats a simultaneous push and pop
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 16'h0030 + 16'(i), 16'hC000 + 16'(i), 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h0040, 16'hC040, 1'b1, 1'b1);
        idle(1'b1);
        step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        idle(1'b0);

        // Push into an empty queue while decode is ready
        step(1'b0, 1'b1, 16'h0020, 16'hD020, 1'b1, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);

        // Random traffic with occasional flushes
        pc = 16'h0100;
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'($urandom_range(0, 3) != 0), pc, 16'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
            pc = pc + 16'd1;
        end
        for (int i = 0; i < 6; i++) idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
